// File: rtl/llki_mock_tss_keymgr.sv
// ----------------------------------------------------------------------------
// llki_mock_tss_keymgr
//
// Mock LLKI key manager sitting in front of a TSS-wrapped core. It accepts a
// KEY_WORDS x 64-bit key over a simple valid/ready channel. It obfuscates the
// host data path with (MOCK_KEY ^ loaded key). It gates the host start strobe
// until a full key has been loaded.
//
// Key channel handshake: a word transfers on every rising edge where
// llkid_key_valid && llkid_key_ready are both high and llkid_clear_key is low.
// The ready signal is registered. It is high only in IDLE/LOAD, and it is low
// during reset, in COMPLETE and in CLEAR. Once the key is complete, valid is
// still observed, but only to flag overflow.
//
// Ports
//   clk                 sole clock, rising edge
//   rst                 synchronous active-high reset
//   llkid_key_data      64-bit key word
//   llkid_key_valid     key word valid
//   llkid_key_ready     key word accepted when valid && ready
//   llkid_key_complete  all KEY_WORDS loaded
//   llkid_clear_key     clear request (pulse)
//   llkid_clear_key_ack one-cycle acknowledge, high while in CLEAR
//   key_overflow        sticky: word offered after completion
//   core_data_in        plaintext block from host
//   core_data_out       obfuscated block to core (combinational)
//   core_start_in       host start strobe
//   core_start_out      start strobe gated by key completion (combinational)
//   blocked_starts      saturating count of starts rejected while incomplete
//   dbg_state           current FSM state (IDLE=0, LOAD=1, COMPLETE=2, CLEAR=3)
// ----------------------------------------------------------------------------
module llki_mock_tss_keymgr #(
   parameter int                      KEY_WORDS = 8,
   parameter int                      DATA_W    = 512,
   parameter logic [64*KEY_WORDS-1:0] MOCK_KEY  = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [63:0]       llkid_key_data,
   input  logic              llkid_key_valid,
   output logic              llkid_key_ready,
   output logic              llkid_key_complete,
   input  logic              llkid_clear_key,
   output logic              llkid_clear_key_ack,
   output logic              key_overflow,
   input  logic [DATA_W-1:0] core_data_in,
   output logic [DATA_W-1:0] core_data_out,
   input  logic              core_start_in,
   output logic              core_start_out,
   output logic [7:0]        blocked_starts,
   output logic [1:0]        dbg_state
);

   localparam int KEY_W = 64 * KEY_WORDS;
   localparam int CNT_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LOAD     = 2'd1,
      ST_COMPLETE = 2'd2,
      ST_CLEAR    = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [KEY_W-1:0] r_key;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ready;
   logic             r_complete;
   logic             r_overflow;
   logic [7:0]       r_blocked;

   logic w_clear_req;
   logic w_accept;
   logic w_last;

   // A clear seen while already clearing is dropped, so only one ack is produced.
   assign w_clear_req = llkid_clear_key && (r_state != ST_CLEAR);
   // A clear beats a simultaneous key word; that word is discarded.
   assign w_accept    = llkid_key_valid && r_ready && !llkid_clear_key;
   assign w_last      = w_accept && (r_cnt == LAST_IDX);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_clear_req) begin
         w_state_nxt = ST_CLEAR;
      end else begin
         case (r_state)
            ST_IDLE, ST_LOAD: begin
               if (w_last) begin
                  w_state_nxt = ST_COMPLETE;
               end else if (w_accept) begin
                  w_state_nxt = ST_LOAD;
               end
            end
            ST_COMPLETE: w_state_nxt = ST_COMPLETE;
            ST_CLEAR:    w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------ datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_key      <= '0;
         r_cnt      <= '0;
         r_ready    <= 1'b0;
         r_complete <= 1'b0;
         r_overflow <= 1'b0;
         r_blocked  <= 8'd0;
      end else if (w_clear_req) begin
         r_key      <= '0;
         r_cnt      <= '0;
         r_ready    <= 1'b0;
         r_complete <= 1'b0;
         r_overflow <= 1'b0;
         r_blocked  <= 8'd0;
      end else begin
         // Ready follows the state being entered, so it is valid as a register.
         r_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD);

         if (w_accept) begin
            for (int i = 0; i < KEY_WORDS; i++) begin
               if (r_cnt == CNT_W'(i)) begin
                  r_key[64*i +: 64] <= llkid_key_data;
               end
            end
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
         end

         if (w_last) begin
            r_complete <= 1'b1;
         end

         if ((r_state == ST_COMPLETE) && llkid_key_valid) begin
            r_overflow <= 1'b1;
         end

         if (core_start_in && !r_complete && (r_blocked != 8'hFF)) begin
            r_blocked <= r_blocked + 8'd1;
         end
      end
   end

   // ------------------------------------------------------------- outputs
   // XOR over the key region is word-wise by construction; upper bits pass.
   always_comb begin
      core_data_out            = core_data_in;
      core_data_out[KEY_W-1:0] = core_data_in[KEY_W-1:0] ^ MOCK_KEY ^ r_key;
   end

   assign core_start_out      = core_start_in && r_complete;
   assign llkid_key_ready     = r_ready;
   assign llkid_key_complete  = r_complete;
   assign llkid_clear_key_ack = (r_state == ST_CLEAR);
   assign key_overflow        = r_overflow;
   assign blocked_starts      = r_blocked;
   assign dbg_state           = r_state;

endmodule

// File: tb/tb_llki_mock_tss_keymgr.sv
// ----------------------------------------------------------------------------
// tb_llki_mock_tss_keymgr
//
// Bench for llki_mock_tss_keymgr with KEY_WORDS=2, DATA_W=128, MOCK_KEY=0.
// Phase 1 applies a directed vector table of inputs and expected outputs.
// Phase 2 checks blocked_starts saturation.
// Phase 3 applies random traffic against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_llki_mock_tss_keymgr;

   localparam int          KW   = 2;
   localparam int          DW   = 128;
   localparam logic [127:0] MOCK = '0;

   // ---------------------------------------------------------- clock/reset
   logic         clk;
   logic         rst;
   logic [63:0]  llkid_key_data;
   logic         llkid_key_valid;
   logic         llkid_key_ready;
   logic         llkid_key_complete;
   logic         llkid_clear_key;
   logic         llkid_clear_key_ack;
   logic         key_overflow;
   logic [DW-1:0] core_data_in;
   logic [DW-1:0] core_data_out;
   logic         core_start_in;
   logic         core_start_out;
   logic [7:0]   blocked_starts;
   logic [1:0]   dbg_state;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   llki_mock_tss_keymgr #(
      .KEY_WORDS (KW),
      .DATA_W    (DW),
      .MOCK_KEY  (MOCK)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .llkid_key_data      (llkid_key_data),
      .llkid_key_valid     (llkid_key_valid),
      .llkid_key_ready     (llkid_key_ready),
      .llkid_key_complete  (llkid_key_complete),
      .llkid_clear_key     (llkid_clear_key),
      .llkid_clear_key_ack (llkid_clear_key_ack),
      .key_overflow        (key_overflow),
      .core_data_in        (core_data_in),
      .core_data_out       (core_data_out),
      .core_start_in       (core_start_in),
      .core_start_out      (core_start_out),
      .blocked_starts      (blocked_starts),
      .dbg_state           (dbg_state)
   );

   // ------------------------------------------------------------- counters
   int n_cmp;
   int n_err;

   task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic e_rdy, input logic e_cmp,
                            input logic e_ack, input logic e_ovf, input logic [7:0] e_blk,
                            input logic e_so, input logic [127:0] e_dout);
      cmp({tag, ".ready"},     128'(llkid_key_ready),     128'(e_rdy));
      cmp({tag, ".complete"},  128'(llkid_key_complete),  128'(e_cmp));
      cmp({tag, ".ack"},       128'(llkid_clear_key_ack), 128'(e_ack));
      cmp({tag, ".overflow"},  128'(key_overflow),        128'(e_ovf));
      cmp({tag, ".blocked"},   128'(blocked_starts),      128'(e_blk));
      cmp({tag, ".start_out"}, 128'(core_start_out),      128'(e_so));
      cmp({tag, ".data_out"},  core_data_out,             e_dout);
   endtask

   // --------------------------------------------------------------- driver
   task automatic drive(input logic i_rst, input logic i_valid, input logic [63:0] i_kd,
                        input logic i_clear, input logic i_start, input logic [127:0] i_din);
      rst             = i_rst;
      llkid_key_valid = i_valid;
      llkid_key_data  = i_kd;
      llkid_clear_key = i_clear;
      core_start_in   = i_start;
      core_data_in    = i_din;
   endtask

   // --------------------------------------------------------- vector table
   typedef struct {
      logic         rst;
      logic         valid;
      logic [63:0]  kd;
      logic         clear;
      logic         start;
      logic [127:0] din;
      logic         e_rdy;
      logic         e_cmp;
      logic         e_ack;
      logic         e_ovf;
      logic [7:0]   e_blk;
      logic         e_so;
      logic [127:0] e_dout;
   } vec_t;

   localparam int NVEC = 25;
   vec_t vecs[NVEC];

   function automatic vec_t mk(input logic r, input logic v, input logic [63:0] kd,
                               input logic c, input logic s, input logic [127:0] din,
                               input logic e_rdy, input logic e_cmp, input logic e_ack,
                               input logic e_ovf, input logic [7:0] e_blk, input logic e_so,
                               input logic [127:0] e_dout);
      vec_t x;
      x.rst = r;  x.valid = v;  x.kd = kd;  x.clear = c;  x.start = s;  x.din = din;
      x.e_rdy = e_rdy;  x.e_cmp = e_cmp;  x.e_ack = e_ack;  x.e_ovf = e_ovf;
      x.e_blk = e_blk;  x.e_so = e_so;  x.e_dout = e_dout;
      return x;
   endfunction

   // ------------------------------------------------------ reference model
   // The loaded key is the list of words accepted since the last clear/reset.
   // The key is complete when that list holds KW words.
   logic [63:0] m_words[$];
   logic        m_ready;
   logic        m_in_clear;
   logic        m_ovf;
   int          m_blocked;

   function automatic logic m_complete();
      return m_words.size() == KW;
   endfunction

   function automatic logic [127:0] m_dout(input logic [127:0] din);
      logic [127:0] d;
      d = din ^ MOCK;
      for (int i = 0; i < KW; i++) begin
         if (i < m_words.size()) d[64*i +: 64] = d[64*i +: 64] ^ m_words[i];
      end
      return d;
   endfunction

   task automatic model_reset();
      m_words.delete();
      m_ready    = 1'b0;
      m_in_clear = 1'b0;
      m_ovf      = 1'b0;
      m_blocked  = 0;
   endtask

   task automatic model_edge(input logic i_rst, input logic i_valid, input logic [63:0] i_kd,
                             input logic i_clear, input logic i_start);
      logic was_ready, was_complete, was_clear;
      if (i_rst) begin
         model_reset();
      end else begin
         was_ready    = m_ready;
         was_complete = m_complete();
         was_clear    = m_in_clear;
         if (i_clear && !was_clear) begin
            m_words.delete();
            m_ovf      = 1'b0;
            m_blocked  = 0;
            m_in_clear = 1'b1;
         end else begin
            m_in_clear = 1'b0;
            if (i_start && !was_complete && m_blocked < 255) m_blocked++;
            if (i_valid && was_ready) m_words.push_back(i_kd);
            else if (i_valid && was_complete) m_ovf = 1'b1;
         end
         m_ready = !m_in_clear && !m_complete();
      end
   endtask

   // ------------------------------------------------------------ stimulus
   localparam logic [63:0]  KA  = 64'hA;
   localparam logic [63:0]  KB  = 64'hB;
   localparam logic [63:0]  KC  = 64'hC;
   localparam logic [127:0] D9  = {64'hFFFF_0000_FFFF_0000, 64'h0123_4567_89AB_CDEF};
   localparam logic [127:0] E9  = {64'hFFFF_0000_FFFF_000B, 64'h0123_4567_89AB_CDE5};
   localparam logic [127:0] KBA = {KB, KA};

   initial begin
      n_cmp = 0;
      n_err = 0;

      //       rst v  kd      clr st din  | rdy cmp ack ovf blk so  dout
      vecs[0]  = mk(1, 0, 64'h0,  0, 0, '0,   0, 0, 0, 0, 8'd0, 0, '0);
      vecs[1]  = mk(0, 0, 64'h0,  0, 1, '0,   0, 0, 0, 0, 8'd0, 0, '0);
      vecs[2]  = mk(0, 0, 64'h0,  0, 1, '0,   1, 0, 0, 0, 8'd1, 0, '0);
      vecs[3]  = mk(0, 0, 64'h0,  0, 1, '0,   1, 0, 0, 0, 8'd2, 0, '0);
      vecs[4]  = mk(0, 0, 64'h0,  0, 0, '0,   1, 0, 0, 0, 8'd3, 0, '0);
      vecs[5]  = mk(0, 1, KA,     0, 0, '0,   1, 0, 0, 0, 8'd3, 0, '0);
      vecs[6]  = mk(0, 1, KB,     0, 0, '0,   1, 0, 0, 0, 8'd3, 0, {64'h0, KA});
      vecs[7]  = mk(0, 0, 64'h0,  0, 1, '0,   0, 1, 0, 0, 8'd3, 1, KBA);
      vecs[8]  = mk(0, 1, KC,     0, 0, '0,   0, 1, 0, 0, 8'd3, 0, KBA);
      vecs[9]  = mk(0, 0, 64'h0,  0, 0, D9,   0, 1, 0, 1, 8'd3, 0, E9);
      vecs[10] = mk(0, 0, 64'h0,  1, 0, '0,   0, 1, 0, 1, 8'd3, 0, KBA);
      vecs[11] = mk(0, 0, 64'h0,  0, 0, '0,   0, 0, 1, 0, 8'd0, 0, '0);
      vecs[12] = mk(0, 0, 64'h0,  0, 0, '0,   1, 0, 0, 0, 8'd0, 0, '0);
      vecs[13] = mk(0, 1, 64'h55, 1, 0, '0,   1, 0, 0, 0, 8'd0, 0, '0);
      vecs[14] = mk(0, 1, 64'h66, 1, 0, '0,   0, 0, 1, 0, 8'd0, 0, '0);
      vecs[15] = mk(0, 0, 64'h0,  0, 0, '0,   1, 0, 0, 0, 8'd0, 0, '0);
      vecs[16] = mk(0, 1, 64'h77, 0, 0, '0,   1, 0, 0, 0, 8'd0, 0, '0);
      vecs[17] = mk(1, 0, 64'h0,  0, 0, '0,   1, 0, 0, 0, 8'd0, 0, {64'h0, 64'h77});
      vecs[18] = mk(0, 0, 64'h0,  0, 0, '0,   0, 0, 0, 0, 8'd0, 0, '0);
      vecs[19] = mk(0, 1, 64'h11, 0, 0, '0,   1, 0, 0, 0, 8'd0, 0, '0);
      vecs[20] = mk(0, 1, 64'h22, 0, 0, '0,   1, 0, 0, 0, 8'd0, 0, {64'h0, 64'h11});
      vecs[21] = mk(0, 0, 64'h0,  0, 1, '0,   0, 1, 0, 0, 8'd0, 1, {64'h22, 64'h11});
      vecs[22] = mk(1, 0, 64'h0,  1, 0, '0,   0, 1, 0, 0, 8'd0, 0, {64'h22, 64'h11});
      vecs[23] = mk(0, 0, 64'h0,  0, 0, '0,   0, 0, 0, 0, 8'd0, 0, '0);
      vecs[24] = mk(0, 0, 64'h0,  0, 0, '0,   1, 0, 0, 0, 8'd0, 0, '0);

      // Power-up reset.
      drive(1, 0, '0, 0, 0, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Phase 1: directed table.
      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].rst, vecs[i].valid, vecs[i].kd, vecs[i].clear, vecs[i].start, vecs[i].din);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_cmp, vecs[i].e_ack,
                   vecs[i].e_ovf, vecs[i].e_blk, vecs[i].e_so, vecs[i].e_dout);
         @(posedge clk);
         @(negedge clk);
      end

      // Phase 2: hold start high while unloaded; the counter saturates at 255.
      for (int n = 1; n <= 300; n++) begin
         drive(0, 0, '0, 0, 1, '0);
         @(posedge clk);
         @(negedge clk);
         if (n == 254) cmp("sat.at254", 128'(blocked_starts), 128'(254));
         if (n == 255) cmp("sat.at255", 128'(blocked_starts), 128'(255));
         if (n == 300) begin
            cmp("sat.at300", 128'(blocked_starts), 128'(255));
            cmp("sat.start_out", 128'(core_start_out), 128'(0));
         end
      end

      // Phase 3: random traffic against the reference model.
      drive(1, 0, '0, 0, 0, '0);
      @(posedge clk);
      @(negedge clk);
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         logic         r_rst, r_valid, r_clear, r_start;
         logic [63:0]  r_kd;
         logic [127:0] r_din;
         r_rst   = ($urandom_range(0, 63) == 0);
         r_valid = ($urandom_range(0, 1) == 1);
         r_clear = ($urandom_range(0, 19) == 0);
         r_start = ($urandom_range(0, 3) == 0);
         r_kd    = {$urandom, $urandom};
         r_din   = {$urandom, $urandom, $urandom, $urandom};
         drive(r_rst, r_valid, r_kd, r_clear, r_start, r_din);
         #1;
         check_all($sformatf("rnd%0d", c), m_ready, m_complete(), m_in_clear, m_ovf,
                   8'(m_blocked), r_start && m_complete(), m_dout(r_din));
         @(posedge clk);
         model_edge(r_rst, r_valid, r_kd, r_clear, r_start);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/llki_mock_tss_keymgr.md
LLKI_MOCK_TSS_KEYMGR -- requirements
Module: llki_mock_tss_keymgr

Interface
REQ-001 SHALL have parameter KEY_WORDS, default 8, number of 64-bit LLKI key words (1..16).
REQ-002 SHALL have parameter DATA_W, default 512, width of the core data path it obfuscates (DATA_W >= 64*KEY_WORDS).
REQ-003 SHALL have parameter MOCK_KEY, default 0, a 64*KEY_WORDS-bit constant mock key.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- llkid_key_data  in  64  key word.
- llkid_key_valid  in  1  key word valid.
- llkid_key_ready  out  1  word accepted when valid&&ready.
- llkid_key_complete  out  1  all KEY_WORDS loaded.
- llkid_clear_key  in  1  clear request, one-cycle pulse.
- llkid_clear_key_ack  out  1  one-cycle clear acknowledge.
- key_overflow  out  1  sticky: word offered after completion.
- core_data_in  in  DATA_W  plaintext block from host.
- core_data_out  out  DATA_W  obfuscated block to core.
- core_start_in  in  1  host start strobe (init/next).
- core_start_out  out  1  gated start strobe to core.
- blocked_starts  out  8  saturating count of rejected starts.

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, COMPLETE, CLEAR.
REQ-006 SHALL drive llkid_key_ready=1 in IDLE and LOAD, 0 in COMPLETE and CLEAR (registered).
REQ-007 SHALL, on valid&&ready, write llkid_key_data to key word index cnt, increment cnt; IDLE->LOAD on first word.
REQ-008 SHALL, on acceptance of word KEY_WORDS-1 (KEY_WORDS=1: the first word), move to COMPLETE next cycle, set llkid_key_complete=1, reset cnt to 0.
REQ-009 SHALL, in COMPLETE, ignore llkid_key_valid data and set key_overflow=1 (sticky until rst or clear).
REQ-010 SHALL, on llkid_clear_key in any state, next cycle enter CLEAR: key register=0, cnt=0, complete=0, key_overflow=0, blocked_starts=0.
REQ-011 SHALL assert llkid_clear_key_ack for exactly one cycle, the cycle in CLEAR, then return to IDLE.
REQ-012 SHALL give llkid_clear_key priority over a simultaneous valid key word; that word is discarded.
REQ-013 SHALL ignore llkid_clear_key asserted while already in CLEAR (no second ack).
REQ-014 SHALL compute core_data_out[64*i+:64] = core_data_in ^ MOCK_KEY ^ key_reg word i for i<KEY_WORDS, combinationally, zero latency.
REQ-015 SHALL pass core_data_out bits above 64*KEY_WORDS unchanged from core_data_in.
REQ-016 SHALL drive core_start_out = core_start_in && llkid_key_complete, combinational.
REQ-017 SHALL increment blocked_starts when core_start_in=1 and llkid_key_complete=0, saturating at 255.
REQ-018 SHALL keep partially loaded key words in register in LOAD (no timeout); completion requires exactly KEY_WORDS accepted words since last clear/reset.

Reset
REQ-019 SHALL, on rst, enter IDLE; key register=0, cnt=0; outputs: llkid_key_ready=0 during rst then 1 first cycle after, llkid_key_complete=0, llkid_clear_key_ack=0, key_overflow=0, blocked_starts=0.
REQ-020 SHALL give rst priority over all inputs, including mid-load and mid-clear (no ack emitted).

Verification (KEY_WORDS=2, DATA_W=128, MOCK_KEY=0)
REQ-021 Load 64'hA, 64'hB back-to-back -> complete=1 one cycle after 2nd handshake, ready=0; data_in=0 -> data_out=128'h0000_000B_..._000A (word1=B, word0=A).
REQ-022 core_start_in pulsed 3 times before load -> core_start_out stays 0, blocked_starts=3; after load, start passes same cycle.
REQ-023 Offer third word 64'hC after complete -> key_overflow=1, data_out unchanged.
REQ-024 Clear pulsed together with first key valid -> word dropped, ack one cycle later for 1 cycle, state IDLE, register 0, ready=1.
REQ-025 rst asserted after one word loaded -> complete=0, register 0; subsequent 2-word load completes normally.
REQ-026 Hold core_start_in high 300 cycles unloaded -> blocked_starts saturates at 255.
